// File: rtl/writeback_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module      : writeback_stage_pkg
// Description : Shared CPU encodings for the writeback path: result-select
//               (wbsel) and load-type (ldtype) codes used by the MEM and WB
//               stages. Ports: none (package only).
// Revision    : 1.0 - initial release
// ============================================================================
package writeback_stage_pkg;

   // Result-select encodings for busW
   localparam logic [1:0] c_WBSEL_ALU  = 2'b00;
   localparam logic [1:0] c_WBSEL_LOAD = 2'b01;
   localparam logic [1:0] c_WBSEL_LINK = 2'b10;
   localparam logic [1:0] c_WBSEL_NONE = 2'b11;

   // Load width/sign encodings; anything above c_LD_HU returns zero
   localparam logic [2:0] c_LD_W  = 3'b000;
   localparam logic [2:0] c_LD_B  = 3'b001;
   localparam logic [2:0] c_LD_BU = 3'b010;
   localparam logic [2:0] c_LD_H  = 3'b011;
   localparam logic [2:0] c_LD_HU = 3'b100;

   // Link address offset (return past the delay slot)
   localparam logic [31:0] c_LINK_OFFSET = 32'd8;

endpackage : writeback_stage_pkg
`default_nettype wire

// File: rtl/writeback_stage_load_ext.sv
`default_nettype none
// ============================================================================
// Module      : load_ext
// Description : Combinational load extraction and sign/zero extension.
//               Little-endian: byte lane selected by addr[1:0], halfword lane
//               by addr[1]. Misaligned low bits are ignored (no trap).
// Ports       : word   [31:0] in  - raw memory word
//               addr   [1:0]  in  - low bits of the load address
//               ldtype [2:0]  in  - load width/sign code
//               value  [31:0] out - extended load result
// Revision    : 1.0 - initial release
// ============================================================================
module load_ext
   import writeback_stage_pkg::*;
(
   input  logic [31:0] word,
   input  logic [1:0]  addr,
   input  logic [2:0]  ldtype,
   output logic [31:0] value
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;

   always_comb begin
      w_byte = word[7:0];
      case (addr)
         2'd0:    w_byte = word[7:0];
         2'd1:    w_byte = word[15:8];
         2'd2:    w_byte = word[23:16];
         default: w_byte = word[31:24];
      endcase
   end

   // addr[0] intentionally ignored for halfwords
   assign w_half = addr[1] ? word[31:16] : word[15:0];

   always_comb begin
      value = 32'd0;
      case (ldtype)
         c_LD_W:  value = word;
         c_LD_B:  value = {{24{w_byte[7]}}, w_byte};
         c_LD_BU: value = {24'd0, w_byte};
         c_LD_H:  value = {{16{w_half[15]}}, w_half};
         c_LD_HU: value = {16'd0, w_half};
         default: value = 32'd0;
      endcase
   end

endmodule : load_ext
`default_nettype wire

// File: rtl/writeback_stage.sv
`default_nettype none
// ============================================================================
// Module      : writeback_stage
// Description : Pipeline writeback stage. Latches MEM-stage results, forms the
//               register-file write (wEn/RW/busW) purely from latched state,
//               mirrors it onto the decode bypass, and counts retirements.
// Ports       : clk, reset (sync, active-low), stall, flush
//               mem_valid, mem_regwrite, mem_rd[4:0], mem_wbsel[1:0],
//               mem_ldtype[2:0], mem_alu/mem_rdata/mem_pc[31:0]  - MEM inputs
//               wEn, RW[4:0], busW[31:0]                       - RF write
//               fwd_valid, fwd_rd[4:0], fwd_data[31:0]         - bypass
//               retired[CNT_W-1:0]                             - retire count
// Revision    : 1.0 - initial release
// ============================================================================
module writeback_stage
   import writeback_stage_pkg::*;
#(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             stall,
   input  logic             flush,
   input  logic             mem_valid,
   input  logic             mem_regwrite,
   input  logic [4:0]       mem_rd,
   input  logic [1:0]       mem_wbsel,
   input  logic [2:0]       mem_ldtype,
   input  logic [31:0]      mem_alu,
   input  logic [31:0]      mem_rdata,
   input  logic [31:0]      mem_pc,
   output logic             wEn,
   output logic [4:0]       RW,
   output logic [31:0]      busW,
   output logic             fwd_valid,
   output logic [4:0]       fwd_rd,
   output logic [31:0]      fwd_data,
   output logic [CNT_W-1:0] retired
);

   localparam logic [CNT_W-1:0] c_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   logic             r_valid;
   logic             r_regwrite;
   logic [4:0]       r_rd;
   logic [1:0]       r_wbsel;
   logic [2:0]       r_ldtype;
   logic [31:0]      r_alu;
   logic [31:0]      r_rdata;
   logic [31:0]      r_pc;
   logic [CNT_W-1:0] r_retired;

   logic [31:0]      w_loadVal;
   logic [31:0]      w_busW;
   logic             w_wEn;

   // WB pipeline register: reset beats flush, flush beats stall.
   // A flush only needs to kill valid; the other fields are don't-care.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_valid    <= 1'b0;
         r_regwrite <= 1'b0;
         r_rd       <= 5'd0;
         r_wbsel    <= 2'd0;
         r_ldtype   <= 3'd0;
         r_alu      <= 32'd0;
         r_rdata    <= 32'd0;
         r_pc       <= 32'd0;
      end else if (flush) begin
         r_valid    <= 1'b0;
      end else if (!stall) begin
         r_valid    <= mem_valid;
         r_regwrite <= mem_regwrite;
         r_rd       <= mem_rd;
         r_wbsel    <= mem_wbsel;
         r_ldtype   <= mem_ldtype;
         r_alu      <= mem_alu;
         r_rdata    <= mem_rdata;
         r_pc       <= mem_pc;
      end
   end

   // An instruction retires on the edge it leaves WB, so a stalled one is
   // counted once even though its write repeats every stalled cycle.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_retired <= '0;
      end else if (r_valid && !stall) begin
         r_retired <= r_retired + c_ONE;
      end
   end

   load_ext u_loadExt (
      .word   (r_rdata),
      .addr   (r_alu[1:0]),
      .ldtype (r_ldtype),
      .value  (w_loadVal)
   );

   always_comb begin
      w_busW = 32'd0;
      case (r_wbsel)
         c_WBSEL_ALU:  w_busW = r_alu;
         c_WBSEL_LOAD: w_busW = w_loadVal;
         c_WBSEL_LINK: w_busW = r_pc + c_LINK_OFFSET;
         default:      w_busW = 32'd0;
      endcase
   end

   assign w_wEn = r_valid & r_regwrite & (r_rd != 5'd0) & (r_wbsel != c_WBSEL_NONE);

   assign wEn       = w_wEn;
   assign RW        = r_rd;
   assign busW      = w_busW;
   assign fwd_valid = w_wEn;
   assign fwd_rd    = r_rd;
   assign fwd_data  = w_busW;
   assign retired   = r_retired;

endmodule : writeback_stage
`default_nettype wire

// File: tb/tb_writeback_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_writeback_stage
// Description : Directed self-checking bench for writeback_stage (CNT_W=4).
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_writeback_stage;

   localparam int CNT_W = 4;

   logic             clk;
   logic             reset;
   logic             stall;
   logic             flush;
   logic             mem_valid;
   logic             mem_regwrite;
   logic [4:0]       mem_rd;
   logic [1:0]       mem_wbsel;
   logic [2:0]       mem_ldtype;
   logic [31:0]      mem_alu;
   logic [31:0]      mem_rdata;
   logic [31:0]      mem_pc;
   logic             wEn;
   logic [4:0]       RW;
   logic [31:0]      busW;
   logic             fwd_valid;
   logic [4:0]       fwd_rd;
   logic [31:0]      fwd_data;
   logic [CNT_W-1:0] retired;

   int checks;
   int errors;

   writeback_stage #(.CNT_W(CNT_W)) dut (
      .clk          (clk),
      .reset        (reset),
      .stall        (stall),
      .flush        (flush),
      .mem_valid    (mem_valid),
      .mem_regwrite (mem_regwrite),
      .mem_rd       (mem_rd),
      .mem_wbsel    (mem_wbsel),
      .mem_ldtype   (mem_ldtype),
      .mem_alu      (mem_alu),
      .mem_rdata    (mem_rdata),
      .mem_pc       (mem_pc),
      .wEn          (wEn),
      .RW           (RW),
      .busW         (busW),
      .fwd_valid    (fwd_valid),
      .fwd_rd       (fwd_rd),
      .fwd_data     (fwd_data),
      .retired      (retired)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one rising edge; outputs are sampled 1ns after it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic rw, input logic [4:0] rd,
                        input logic [1:0] ws, input logic [2:0] lt,
                        input logic [31:0] alu, input logic [31:0] rdata,
                        input logic [31:0] pc);
      mem_valid    = v;
      mem_regwrite = rw;
      mem_rd       = rd;
      mem_wbsel    = ws;
      mem_ldtype   = lt;
      mem_alu      = alu;
      mem_rdata    = rdata;
      mem_pc       = pc;
   endtask

   task automatic do_reset();
      reset = 1'b0;
      step();
      reset = 1'b1;
   endtask

   task automatic test_reset();
      drive(1'b1, 1'b1, 5'd7, 2'b00, 3'b000, 32'h1111_2222, 32'h0, 32'h0);
      reset = 1'b0;
      step();
      checks++;
      if (wEn !== 1'b0 || RW !== 5'd0 || busW !== 32'd0 || fwd_valid !== 1'b0 || retired !== 4'd0) begin
         errors++;
         $display("FAIL reset: wEn=%b RW=%0d busW=%h fwd_valid=%b retired=%0d, required 0/0/0/0/0",
                  wEn, RW, busW, fwd_valid, retired);
      end
      reset = 1'b1;
   endtask

   task automatic test_load_byte();
      drive(1'b1, 1'b1, 5'd5, 2'b01, 3'b001, 32'h0000_1002, 32'h80FF_7F01, 32'h0);
      step();
      checks++;
      if (wEn !== 1'b1 || RW !== 5'd5 || busW !== 32'hFFFF_FFFF) begin
         errors++;
         $display("FAIL lb: wEn=%b RW=%0d busW=%h, required 1/5/ffffffff", wEn, RW, busW);
      end
      checks++;
      if (fwd_valid !== 1'b1 || fwd_rd !== 5'd5 || fwd_data !== 32'hFFFF_FFFF) begin
         errors++;
         $display("FAIL fwd_lb: valid=%b rd=%0d data=%h, required 1/5/ffffffff", fwd_valid, fwd_rd, fwd_data);
      end
      mem_ldtype = 3'b010;
      step();
      checks++;
      if (busW !== 32'h0000_00FF) begin
         errors++;
         $display("FAIL lbu: busW=%h, required 000000ff", busW);
      end
      mem_ldtype = 3'b001;
      mem_alu    = 32'h0000_1000;
      step();
      checks++;
      if (busW !== 32'h0000_0001) begin
         errors++;
         $display("FAIL lb_lane0: busW=%h, required 00000001", busW);
      end
      mem_alu = 32'h0000_1001;
      step();
      checks++;
      if (busW !== 32'h0000_007F) begin
         errors++;
         $display("FAIL lb_lane1: busW=%h, required 0000007f", busW);
      end
      mem_alu = 32'h0000_1003;
      step();
      checks++;
      if (busW !== 32'hFFFF_FF80) begin
         errors++;
         $display("FAIL lb_lane3: busW=%h, required ffffff80", busW);
      end
   endtask

   task automatic test_load_half();
      drive(1'b1, 1'b1, 5'd9, 2'b01, 3'b011, 32'h0000_1002, 32'h8001_7FFE, 32'h0);
      step();
      checks++;
      if (busW !== 32'hFFFF_8001) begin
         errors++;
         $display("FAIL lh: busW=%h, required ffff8001", busW);
      end
      mem_ldtype = 3'b100;
      step();
      checks++;
      if (busW !== 32'h0000_8001) begin
         errors++;
         $display("FAIL lhu: busW=%h, required 00008001", busW);
      end
      mem_ldtype = 3'b011;
      mem_alu    = 32'h0000_1003;
      step();
      checks++;
      if (busW !== 32'hFFFF_8001) begin
         errors++;
         $display("FAIL lh_odd: busW=%h, required ffff8001", busW);
      end
      mem_alu = 32'h0000_1000;
      step();
      checks++;
      if (busW !== 32'h0000_7FFE) begin
         errors++;
         $display("FAIL lh_low: busW=%h, required 00007ffe", busW);
      end
      mem_ldtype = 3'b000;
      mem_alu    = 32'h0000_1003;
      step();
      checks++;
      if (busW !== 32'h8001_7FFE) begin
         errors++;
         $display("FAIL lw_misaligned: busW=%h, required 80017ffe", busW);
      end
      mem_ldtype = 3'b101;
      step();
      checks++;
      if (busW !== 32'h0000_0000) begin
         errors++;
         $display("FAIL ld_reserved: busW=%h, required 00000000", busW);
      end
   endtask

   task automatic test_alu_and_link();
      drive(1'b1, 1'b1, 5'd12, 2'b00, 3'b000, 32'hCAFE_BABE, 32'h1234_5678, 32'h0000_0100);
      step();
      checks++;
      if (busW !== 32'hCAFE_BABE || wEn !== 1'b1 || RW !== 5'd12) begin
         errors++;
         $display("FAIL alu: busW=%h wEn=%b RW=%0d, required cafebabe/1/12", busW, wEn, RW);
      end
      drive(1'b1, 1'b1, 5'd31, 2'b10, 3'b000, 32'h0, 32'h0, 32'hFFFF_FFFC);
      step();
      checks++;
      if (busW !== 32'h0000_0004 || wEn !== 1'b1 || RW !== 5'd31) begin
         errors++;
         $display("FAIL link: busW=%h wEn=%b RW=%0d, required 00000004/1/31", busW, wEn, RW);
      end
      mem_rd = 5'd0;
      step();
      checks++;
      if (wEn !== 1'b0 || fwd_valid !== 1'b0 || busW !== 32'h0000_0004) begin
         errors++;
         $display("FAIL link_rd0: wEn=%b fwd_valid=%b busW=%h, required 0/0/00000004", wEn, fwd_valid, busW);
      end
      drive(1'b1, 1'b1, 5'd3, 2'b11, 3'b000, 32'h5555_5555, 32'h0, 32'h0);
      step();
      checks++;
      if (wEn !== 1'b0 || busW !== 32'd0) begin
         errors++;
         $display("FAIL wbsel11: wEn=%b busW=%h, required 0/00000000", wEn, busW);
      end
      drive(1'b1, 1'b0, 5'd3, 2'b00, 3'b000, 32'h5555_5555, 32'h0, 32'h0);
      step();
      checks++;
      if (wEn !== 1'b0) begin
         errors++;
         $display("FAIL no_regwrite: wEn=%b, required 0", wEn);
      end
      drive(1'b0, 1'b1, 5'd3, 2'b00, 3'b000, 32'h5555_5555, 32'h0, 32'h0);
      step();
      checks++;
      if (wEn !== 1'b0) begin
         errors++;
         $display("FAIL not_valid: wEn=%b, required 0", wEn);
      end
   endtask

   task automatic test_stall_flush();
      do_reset();
      drive(1'b1, 1'b1, 5'd3, 2'b00, 3'b000, 32'h0000_1234, 32'h0, 32'h0);
      step();
      checks++;
      if (busW !== 32'h0000_1234 || wEn !== 1'b1 || retired !== 4'd0) begin
         errors++;
         $display("FAIL stall_capture: busW=%h wEn=%b retired=%0d, required 00001234/1/0", busW, wEn, retired);
      end
      stall = 1'b1;
      drive(1'b1, 1'b1, 5'd8, 2'b00, 3'b000, 32'hDEAD_BEEF, 32'h0, 32'h0);
      for (int i = 0; i < 3; i++) begin
         step();
         checks++;
         if (busW !== 32'h0000_1234 || wEn !== 1'b1 || RW !== 5'd3 || retired !== 4'd0) begin
            errors++;
            $display("FAIL stall_hold[%0d]: busW=%h wEn=%b RW=%0d retired=%0d, required 00001234/1/3/0",
                     i, busW, wEn, RW, retired);
         end
      end
      stall     = 1'b0;
      mem_valid = 1'b0;
      step();
      checks++;
      if (retired !== 4'd1 || wEn !== 1'b0) begin
         errors++;
         $display("FAIL stall_release: retired=%0d wEn=%b, required 1/0", retired, wEn);
      end
      mem_valid = 1'b1;
      step();
      checks++;
      if (wEn !== 1'b1 || busW !== 32'hDEAD_BEEF || retired !== 4'd1) begin
         errors++;
         $display("FAIL pre_flush: wEn=%b busW=%h retired=%0d, required 1/deadbeef/1", wEn, busW, retired);
      end
      stall = 1'b1;
      flush = 1'b1;
      step();
      checks++;
      if (wEn !== 1'b0 || fwd_valid !== 1'b0 || retired !== 4'd1) begin
         errors++;
         $display("FAIL stall_flush: wEn=%b fwd_valid=%b retired=%0d, required 0/0/1", wEn, fwd_valid, retired);
      end
      stall = 1'b0;
      flush = 1'b0;
   endtask

   task automatic test_reset_mid_stall();
      drive(1'b1, 1'b1, 5'd17, 2'b00, 3'b000, 32'h0BAD_F00D, 32'h0, 32'h0);
      step();
      stall = 1'b1;
      step();
      checks++;
      if (wEn !== 1'b1 || retired === 4'd0) begin
         errors++;
         $display("FAIL pre_reset_stall: wEn=%b retired=%0d, required 1/nonzero", wEn, retired);
      end
      reset = 1'b0;
      step();
      checks++;
      if (wEn !== 1'b0 || RW !== 5'd0 || busW !== 32'd0 || fwd_valid !== 1'b0 ||
          fwd_rd !== 5'd0 || fwd_data !== 32'd0 || retired !== 4'd0) begin
         errors++;
         $display("FAIL reset_mid_stall: wEn=%b RW=%0d busW=%h fwd=%b/%0d/%h retired=%0d, required all 0",
                  wEn, RW, busW, fwd_valid, fwd_rd, fwd_data, retired);
      end
      reset = 1'b1;
      stall = 1'b0;
   endtask

   task automatic test_wrap();
      do_reset();
      drive(1'b1, 1'b1, 5'd1, 2'b00, 3'b000, 32'h1, 32'h0, 32'h0);
      // First edge only captures; each later edge retires one.
      for (int i = 0; i < 16; i++) step();
      checks++;
      if (retired !== 4'd15) begin
         errors++;
         $display("FAIL wrap_15: retired=%0d, required 15", retired);
      end
      step();
      checks++;
      if (retired !== 4'd0) begin
         errors++;
         $display("FAIL wrap_0: retired=%0d, required 0", retired);
      end
      mem_valid = 1'b0;
      step();
      step();
      checks++;
      if (retired !== 4'd1) begin
         errors++;
         $display("FAIL wrap_after: retired=%0d, required 1", retired);
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      reset  = 1'b0;
      stall  = 1'b0;
      flush  = 1'b0;
      drive(1'b0, 1'b0, 5'd0, 2'b00, 3'b000, 32'h0, 32'h0, 32'h0);
      test_reset();
      test_load_byte();
      test_load_half();
      test_alu_and_link();
      test_stall_flush();
      test_reset_mid_stall();
      test_wrap();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_writeback_stage
`default_nettype wire

// File: doc/writeback_stage.md
WRITEBACK_STAGE -- requirements
Module: writeback_stage

Interface
REQ-001 SHALL have parameter: CNT_W, 32, width of retired-instruction counter.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: reset  input  1  synchronous, active-low reset, sampled on rising clk.
REQ-004 SHALL have ports: stall  input  1  hold stage; flush  input  1  kill incoming instruction.
REQ-005 SHALL have ports: mem_valid  input  1; mem_regwrite  input  1; mem_rd  input  5  destination register.
REQ-006 SHALL have ports: mem_wbsel  input  2  result select; mem_ldtype  input  3  load width/sign.
REQ-007 SHALL have ports: mem_alu  input  32  ALU result/load address; mem_rdata  input  32  memory word; mem_pc  input  32  instruction PC.
REQ-008 SHALL have ports: wEn  output  1; RW  output  5; busW  output  32 (register-file write port).
REQ-009 SHALL have ports: fwd_valid  output  1; fwd_rd  output  5; fwd_data  output  32 (bypass to decode); retired  output  CNT_W.

Function
REQ-010 SHALL latch all mem_* inputs into the WB register on a rising edge when stall=0 and flush=0.
REQ-011 SHALL clear the latched valid bit (other fields don't-care) on a rising edge when flush=1, regardless of stall (flush beats stall).
REQ-012 SHALL hold all latched state unchanged when stall=1 and flush=0.
REQ-013 SHALL present busW one cycle after MEM capture, combinationally from latched fields only (no mem_* to output path).
REQ-014 SHALL select busW by wbsel: 00 ALU result; 01 extended load data; 10 PC+8 (link, modulo 2^32); 11 zero.
REQ-015 SHALL extend loads per ldtype: 000 LW full word; 001 LB / 010 LBU byte at alu[1:0] little-endian, sign/zero-extended; 011 LH / 100 LHU halfword at alu[1], sign/zero-extended; 101-111 zero.
REQ-016 SHALL ignore alu[0] for halfword and alu[1:0] for word loads (no misalignment trap).
REQ-017 SHALL drive wEn = valid & regwrite & (rd!=0) & (wbsel!=11); RW = latched rd at all times.
REQ-018 SHALL drive fwd_valid = wEn, fwd_rd = RW, fwd_data = busW.
REQ-019 SHALL keep wEn/RW/busW stable from one rising edge to the next, so a falling-edge-sampling register file captures settled data.
REQ-020 SHALL increment retired by 1 on each rising edge where latched valid=1 and stall=0, wrapping at 2^CNT_W.
REQ-021 SHALL count a stalled instruction exactly once (on the edge it leaves), though wEn may assert repeatedly with identical data.

Reset
REQ-022 SHALL, on a rising edge with reset=0, clear valid, regwrite, rd, wbsel, ldtype, alu, rdata, pc and retired to 0, overriding stall and flush.
REQ-023 SHALL therefore drive wEn=0, RW=0, busW=0, fwd_valid=0, retired=0 in the cycle after reset, including mid-stall.

Structure
REQ-024 SHALL take wbsel and ldtype encodings from the shared CPU package constants, not local literals.
REQ-025 SHALL implement load extraction/extension in one combinational sub-module load_ext (inputs word, addr[1:0], ldtype; output 32-bit value).

Verification
REQ-026 SHALL cover LB: rdata=0x80FF7F01, alu=0x1002, ldtype=001, wbsel=01, rd=5 -> next cycle wEn=1, RW=5, busW=0xFFFFFFFF; with LBU busW=0x000000FF.
REQ-027 SHALL cover LH/LHU: rdata=0x8001_7FFE, alu[1]=1 -> LH busW=0xFFFF8001, LHU busW=0x00008001.
REQ-028 SHALL cover link and rd=0: wbsel=10, pc=0xFFFFFFFC, rd=31 -> busW=0x00000004, wEn=1; same with rd=0 -> wEn=0.
REQ-029 SHALL cover stall/flush: valid instr, then stall=1 three cycles -> busW held, retired +1 only on release; stall=1 with flush=1 -> wEn=0 next cycle.
REQ-030 SHALL cover reset mid-stall and wrap: CNT_W=4, 16 retirements -> retired=0; reset=0 during stall -> all outputs 0 next cycle.
